// File: rtl/parity_frame_receiver_if.sv
// Bus between a serial line source and the parity frame receiver.
// Handshake: data_valid is a one-cycle strobe with no back-pressure (there is
// no ready). The consumer must take data_out, parity_error and framing_error
// in the cycle data_valid is high; they stay stable until the next strobe.
interface parity_frame_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_serial;
    logic                  odd_parity_sel;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  parity_error;
    logic                  framing_error;
    logic                  busy;
    logic [2:0]            state_dbg;

    // Line side: drives the serial line and parity mode, observes results.
    modport master (
        output rx_serial,
        output odd_parity_sel,
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  framing_error,
        input  busy,
        input  state_dbg
    );

    // Receiver side.
    modport slave (
        input  rx_serial,
        input  odd_parity_sel,
        output data_out,
        output data_valid,
        output parity_error,
        output framing_error,
        output busy,
        output state_dbg
    );
endinterface

// File: rtl/parity_frame_receiver.sv
// Serial receiver for start + DATA_WIDTH data bits (LSB first) + parity + stop
// frames. Samples every bit mid-period, checks odd/even parity and the stop
// bit, and delivers the word with a one-cycle data_valid strobe.
module parity_frame_receiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    parity_frame_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  rx_meta;
    logic                  rx_s;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bit;
    logic                  par_mode;
    logic                  cnt_mid;
    logic                  cnt_last;
    logic                  p;

    assign cnt_mid  = (cnt == CNT_MID);
    assign cnt_last = (cnt == CNT_LAST);
    // Odd number of ones across data and parity bit.
    assign p        = ^{shift, par_bit};

    assign bus.busy      = (state != IDLE);
    assign bus.state_dbg = state;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx_serial;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; every bit is sampled at its mid-point.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_s) state_next = START;
            START:   if (cnt_mid) state_next = rx_s ? IDLE : DATA;
            DATA:    if (cnt_last && (idx == IDX_LAST)) state_next = PARITY;
            PARITY:  if (cnt_last) state_next = STOP;
            STOP:    if (cnt_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit-period counter: cleared on state change and at each bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state_next != state) || cnt_last || (state == IDLE)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shift register, bit index, parity bit and latched parity mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            par_mode <= 1'b0;
        end else begin
            if ((state == START) && cnt_mid && !rx_s) begin
                idx      <= '0;
                par_mode <= bus.odd_parity_sel;
            end
            if ((state == DATA) && cnt_last) begin
                shift[idx] <= rx_s;
                idx        <= idx + IDX_W'(1);
            end
            if ((state == PARITY) && cnt_last) begin
                par_bit <= rx_s;
            end
        end
    end

    // Outputs load on the edge entering DONE so they are visible during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_out      <= '0;
            bus.parity_error  <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.data_valid    <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            if ((state == STOP) && cnt_last) begin
                bus.data_out      <= shift;
                bus.parity_error  <= par_mode ? ~p : p;
                bus.framing_error <= ~rx_s;
                bus.data_valid    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench for parity_frame_receiver: drives hand-built frames and
// checks delivered words, flags, strobe timing and reset/glitch behaviour.
module tb_parity_frame_receiver;
    localparam int DATA_WIDTH   = 8;
    localparam int CLKS_PER_BIT = 16;
    // Cycles from first rx_s low to data_valid, plus 2 for the synchroniser.
    localparam int LATENCY      = 1 + (CLKS_PER_BIT / 2 - 1) + (DATA_WIDTH + 2) * CLKS_PER_BIT + 1;
    localparam int LINE_LATENCY = LATENCY + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_WIDTH+1:0] exp_q[$];
    int   pulse_cnt  = 0;
    logic prev_valid = 1'b0;
    int   lat_start  = 0;
    logic lat_armed  = 1'b0;

    parity_frame_receiver_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    parity_frame_receiver #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [DATA_WIDTH-1:0] d, input logic perr, input logic ferr);
        exp_q.push_back({ferr, perr, d});
    endtask

    task automatic drive_bit(input logic b);
        bus.rx_serial = b;
        repeat (CLKS_PER_BIT) @(negedge clk);
    endtask

    // Sends one frame; optionally flips odd_parity_sel during the data bits
    // and restores it before the parity bit.
    task automatic send_frame(input logic [DATA_WIDTH-1:0] d, input logic par, input logic stop,
                              input logic flip_sel, input logic time_it);
        if (time_it) begin
            lat_start = cyc;
            lat_armed = 1'b1;
        end
        drive_bit(1'b0);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (flip_sel && i == 3) bus.odd_parity_sel = ~bus.odd_parity_sel;
            drive_bit(d[i]);
        end
        if (flip_sel) bus.odd_parity_sel = ~bus.odd_parity_sel;
        drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check_val("drain", exp_q.size(), 0);
    endtask

    // Scoreboard: every strobe is matched against the expected queue.
    always @(negedge clk) begin
        logic [DATA_WIDTH+1:0] e;
        if (!rst && bus.data_valid) begin
            pulse_cnt++;
            check_val("valid_width", {31'd0, prev_valid}, 0);
            if (exp_q.size() == 0) begin
                check_val("spurious_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("data", bus.data_out, e[DATA_WIDTH-1:0]);
                check_val("parity_error", bus.parity_error, e[DATA_WIDTH]);
                check_val("framing_error", bus.framing_error, e[DATA_WIDTH+1]);
            end
            if (lat_armed) begin
                check_val("latency", cyc - lat_start, LINE_LATENCY);
                lat_armed = 1'b0;
            end
        end
        prev_valid = bus.data_valid;
    end

    initial begin
        int pulses_before;
        int waited;

        bus.rx_serial      = 1'b1;
        bus.odd_parity_sel = 1'b0;
        rst                = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_data_out", bus.data_out, 0);
        check_val("rst_valid", bus.data_valid, 0);
        check_val("rst_perr", bus.parity_error, 0);
        check_val("rst_ferr", bus.framing_error, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_state", bus.state_dbg, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Even parity, clean frame, timed.
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain();

        // Odd parity: 0xA5 with parity 0 is wrong, 0x07 with parity 0 is right.
        bus.odd_parity_sel = 1'b1;
        push_exp(8'hA5, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain();
        bus.odd_parity_sel = 1'b0;

        // Framing error, then a clean frame clears both flags.
        push_exp(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.rx_serial = 1'b1;
        repeat (2 * CLKS_PER_BIT) @(negedge clk);
        check_val("ferr_recover_idle", bus.busy, 0);
        push_exp(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain();
        repeat (CLKS_PER_BIT) @(negedge clk);

        // Glitch rejection: 4 low cycles.
        pulses_before = pulse_cnt;
        bus.rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        check_val("glitch_busy_set", bus.busy, 1);
        @(negedge clk);
        bus.rx_serial = 1'b1;
        waited = 4;
        while (bus.busy && waited < CLKS_PER_BIT / 2 + 3) begin
            @(negedge clk);
            waited++;
        end
        check_val("glitch_busy_clear", bus.busy, 0);
        repeat (2 * CLKS_PER_BIT) @(negedge clk);
        check_val("glitch_no_valid", pulse_cnt - pulses_before, 0);
        check_val("glitch_data_hold", bus.data_out, 8'h81);
        check_val("glitch_perr_hold", bus.parity_error, 0);
        check_val("glitch_ferr_hold", bus.framing_error, 0);

        // Reset after the 4th data bit of 0xFF.
        pulses_before = pulse_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst = 1'b1;
        #1;
        check_val("midrst_data_out", bus.data_out, 0);
        check_val("midrst_valid", bus.data_valid, 0);
        check_val("midrst_perr", bus.parity_error, 0);
        check_val("midrst_ferr", bus.framing_error, 0);
        check_val("midrst_busy", bus.busy, 0);
        bus.rx_serial = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CLKS_PER_BIT) @(negedge clk);
        check_val("midrst_no_valid", pulse_cnt - pulses_before, 0);
        push_exp(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain();
        repeat (CLKS_PER_BIT) @(negedge clk);

        // Back-to-back frames with mid-frame parity-mode toggles.
        pulses_before = pulse_cnt;
        push_exp(8'h01, 1'b0, 1'b0);
        push_exp(8'h80, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain();
        repeat (CLKS_PER_BIT) @(negedge clk);
        check_val("b2b_pulses", pulse_cnt - pulses_before, 3);
        check_val("final_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
